reg_wb_arbiter: RTL

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter: round-robin between the ALU and load-unit channels onto one
// register-file write port, plus a pending-writeback scoreboard for hazard queries.
module reg_wb_arbiter #(
    parameter int REG_SIZE   = 32,
    parameter int NO_OF_REGS = 32,
    parameter int REGW       = $clog2(NO_OF_REGS)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [REGW-1:0]       alu_waddr_i,
    input  logic [REG_SIZE-1:0]   alu_wdata_i,
    input  logic                  lsu_valid_i,
    output logic                  lsu_ready_o,
    input  logic [REGW-1:0]       lsu_waddr_i,
    input  logic [REG_SIZE-1:0]   lsu_wdata_i,
    output logic                  we_o,
    output logic [REGW-1:0]       waddr_o,
    output logic [REG_SIZE-1:0]   wdata_o,
    input  logic                  iss_valid_i,
    input  logic [REGW-1:0]       iss_rd_i,
    input  logic [REGW-1:0]       chk_addr1_i,
    input  logic [REGW-1:0]       chk_addr2_i,
    output logic                  busy1_o,
    output logic                  busy2_o,
    output logic [NO_OF_REGS-1:0] pending_o
);

    logic                  alu_gnt_s;
    logic                  lsu_gnt_s;
    logic                  last_lsu_q;
    logic                  last_lsu_d;
    logic                  we_q;
    logic                  we_d;
    logic [REGW-1:0]       waddr_q;
    logic [REGW-1:0]       waddr_d;
    logic [REG_SIZE-1:0]   wdata_q;
    logic [REG_SIZE-1:0]   wdata_d;
    logic [NO_OF_REGS-1:0] pending_q;
    logic [NO_OF_REGS-1:0] pending_d;
    logic                  busy1_s;
    logic                  busy2_s;

    // Grant: sole requester wins; on contention the channel that did not win last time wins.
    always_comb begin
        alu_gnt_s = 1'b0;
        lsu_gnt_s = 1'b0;
        if (rst_i) begin
            alu_gnt_s = 1'b0;
            lsu_gnt_s = 1'b0;
        end else begin
            case ({alu_valid_i, lsu_valid_i})
                2'b10:   alu_gnt_s = 1'b1;
                2'b01:   lsu_gnt_s = 1'b1;
                2'b11: begin
                    alu_gnt_s = last_lsu_q;
                    lsu_gnt_s = ~last_lsu_q;
                end
                default: begin
                    alu_gnt_s = 1'b0;
                    lsu_gnt_s = 1'b0;
                end
            endcase
        end
    end

    // Next-state for the write port and round-robin pointer; x0 writes are accepted but suppressed.
    always_comb begin
        we_d       = 1'b0;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        last_lsu_d = last_lsu_q;
        if (alu_gnt_s) begin
            we_d       = (alu_waddr_i != '0);
            waddr_d    = alu_waddr_i;
            wdata_d    = alu_wdata_i;
            last_lsu_d = 1'b0;
        end else if (lsu_gnt_s) begin
            we_d       = (lsu_waddr_i != '0);
            waddr_d    = lsu_waddr_i;
            wdata_d    = lsu_wdata_i;
            last_lsu_d = 1'b1;
        end else begin
            we_d       = 1'b0;
        end
    end

    // Scoreboard next-state: an issue reservation overrides a retiring write to the same register.
    always_comb begin
        pending_d    = '0;
        pending_d[0] = 1'b0;
        for (int i = 1; i < NO_OF_REGS; i++) begin
            pending_d[i] = (iss_valid_i && (iss_rd_i == REGW'(i))) ||
                           (pending_q[i] && !(we_q && (waddr_q == REGW'(i))));
        end
    end

    // Hazard query lookup; register 0 is never pending so it reads as not busy.
    always_comb begin
        busy1_s = 1'b0;
        busy2_s = 1'b0;
        for (int i = 0; i < NO_OF_REGS; i++) begin
            busy1_s = busy1_s | (pending_q[i] & (chk_addr1_i == REGW'(i)));
            busy2_s = busy2_s | (pending_q[i] & (chk_addr2_i == REGW'(i)));
        end
    end

    // State registers; reset leaves the LSU as last winner so the ALU takes the first contest.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_lsu_q <= 1'b1;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            pending_q  <= '0;
        end else begin
            last_lsu_q <= last_lsu_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            pending_q  <= pending_d;
        end
    end

    assign alu_ready_o = alu_gnt_s;
    assign lsu_ready_o = lsu_gnt_s;
    assign we_o        = we_q;
    assign waddr_o     = waddr_q;
    assign wdata_o     = wdata_q;
    assign busy1_o     = busy1_s;
    assign busy2_o     = busy2_s;
    assign pending_o   = pending_q;

endmodule
